// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer controllers (read and
// write side): default address width, pointer-width helper, and Gray/binary
// conversion functions.
// Functions operate on a 32-bit container; callers zero-extend narrower
// pointers, which leaves the conversion of the low bits unchanged.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int CONV_W         = 32;

  // Pointers carry one extra wrap bit beyond the memory address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix-XOR from the MSB down, done in log2 steps.
  function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray);
    logic [CONV_W-1:0] bin;
    bin = gray;
    bin = bin ^ (bin >> 1);
    bin = bin ^ (bin >> 2);
    bin = bin ^ (bin >> 4);
    bin = bin ^ (bin >> 8);
    bin = bin ^ (bin >> 16);
    return bin;
  endfunction

endpackage

// File: rtl/read_ptr_gray_ctrl_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Combinational Gray-to-binary converter of parametrised width. Used on the
// synchronised write pointer in the read domain and on the synchronised read
// pointer in the write domain.
//
// Ports:
//   gray_i  in  W  Gray-coded value
//   bin_o   out W  binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
  parameter int W = 7
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at and above its position;
  // written per bit so there is no chained dependency on bin_o itself.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/read_ptr_gray_ctrl.sv
// -----------------------------------------------------------------------------
// read_ptr_gray_ctrl
// Read-side pointer and status controller of the asynchronous FIFO. Keeps the
// read pointer in binary and Gray form, produces a look-ahead registered empty
// flag against the synchronised Gray write pointer, and a registered fill
// level with an almost-empty flag.
//
// Optional feature macro: RPTR_UNDERFLOW_EN adds a sticky underflow output set
// by any read request while empty.
//
// Parameters:
//   ADDR_WIDTH  memory address width; depth = 2**ADDR_WIDTH
//   AE_THRESH   almost_empty asserts when level <= AE_THRESH
//
// Ports:
//   clk           in   1             read-domain clock
//   rst_n         in   1             asynchronous active-low reset
//   inc           in   1             read request, accepted only when not empty
//   rq2_wptr      in   ADDR_WIDTH+1  Gray write pointer, synchronised to clk
//   rptr          out  ADDR_WIDTH+1  Gray read pointer (to read->write sync)
//   raddr         out  ADDR_WIDTH    memory read address
//   empty         out  1             registered empty flag
//   almost_empty  out  1             registered, level <= AE_THRESH
//   rlevel        out  ADDR_WIDTH+1  registered fill level
//   underflow     out  1             sticky read-while-empty (macro only)
// -----------------------------------------------------------------------------
module read_ptr_gray_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rlevel
`ifdef RPTR_UNDERFLOW_EN
  ,
  output logic                  underflow
`endif
);

  localparam int            PW     = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] rbin_q,  rbin_d;
  logic [PW-1:0] rptr_q,  rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          ae_q,    ae_d;
  logic [PW-1:0] wbin;
  logic          rd_ok;

  gray2bin #(.W(PW)) u_wptr_g2b (
    .gray_i (rq2_wptr),
    .bin_o  (wbin)
  );

  assign rd_ok = inc & ~empty_q;

  // Flags and level are evaluated on the post-increment pointer, so the read
  // that drains the last word raises empty on the same edge (look-ahead).
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rbin_d  = rbin_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    empty_d = empty_q;
    ae_d    = ae_q;

    rbin_d  = rbin_q + PW'(rd_ok);
    rptr_d  = rbin_d ^ (rbin_d >> 1);
    // Modular subtract: wrap of either pointer still yields the true level.
    level_d = wbin - rbin_d;
    empty_d = (rptr_d == rq2_wptr);
    ae_d    = (level_d <= AE_LVL);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
    end else begin
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // Sticky: only reset clears it.
  assign underflow_d = underflow_q | (inc & empty_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underflow_q <= 1'b0;
    else        underflow_q <= underflow_d;
  end

  assign underflow = underflow_q;
`endif

  assign rptr         = rptr_q;
  assign raddr        = rbin_q[ADDR_WIDTH-1:0];
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rlevel       = level_q;

endmodule

// File: tb/tb_read_ptr_gray_ctrl.sv
// -----------------------------------------------------------------------------
// tb_read_ptr_gray_ctrl
// Self-checking bench for read_ptr_gray_ctrl (ADDR_WIDTH=6, AE_THRESH=4).
// The reference model tracks total words written and read as plain integers;
// every expected output is derived from those two counts. Define
// RPTR_UNDERFLOW_EN to also exercise the underflow output.
// -----------------------------------------------------------------------------
module tb_read_ptr_gray_ctrl;

  localparam int AW    = 6;
  localparam int AE    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << (AW + 1);

  logic          clk;
  logic          rst_n;
  logic          inc;
  logic [AW:0]   rq2_wptr;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic          empty;
  logic          almost_empty;
  logic [AW:0]   rlevel;
`ifdef RPTR_UNDERFLOW_EN
  logic          underflow;
`endif

  read_ptr_gray_ctrl #(
    .ADDR_WIDTH (AW),
    .AE_THRESH  (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inc          (inc),
    .rq2_wptr     (rq2_wptr),
    .rptr         (rptr),
    .raddr        (raddr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rlevel       (rlevel)
`ifdef RPTR_UNDERFLOW_EN
    ,
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: running totals of words written/read.
  int   wr_count;
  int   rd_count;
  logic exp_empty;
  logic exp_ae;
  int   exp_level;
  logic exp_uf;

  int checks;
  int errors;

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(v % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0h exp %0h (rd=%0d wr=%0d)", tag, got, exp, rd_count, wr_count);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":rptr"},  32'(rptr),         32'(to_gray(rd_count)));
    chk({tag, ":raddr"}, 32'(raddr),        32'(rd_count % DEPTH));
    chk({tag, ":empty"}, 32'(empty),        32'(exp_empty));
    chk({tag, ":ae"},    32'(almost_empty), 32'(exp_ae));
    chk({tag, ":level"}, 32'(rlevel),       32'(exp_level));
`ifdef RPTR_UNDERFLOW_EN
    chk({tag, ":uf"},    32'(underflow),    32'(exp_uf));
`endif
  endtask

  task automatic model_reset();
    rd_count  = 0;
    exp_empty = 1'b1;
    exp_ae    = 1'b1;
    exp_level = 0;
    exp_uf    = 1'b0;
  endtask

  // One clock: apply inputs, advance one edge, update model, check outputs.
  task automatic step(input logic inc_v, input int wr_inc, input string tag);
    wr_count = wr_count + wr_inc;
    rq2_wptr = to_gray(wr_count);
    inc      = inc_v;
    @(posedge clk);
    if (inc_v && exp_empty) exp_uf = 1'b1;
    if (inc_v && !exp_empty) rd_count++;
    exp_level = wr_count - rd_count;
    exp_empty = (exp_level == 0);
    exp_ae    = (exp_level <= AE);
    #1;
    check_all(tag);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    wr_count = 0;
    model_reset();
    rst_n    = 1'b0;
    inc      = 1'b1;
    rq2_wptr = '0;

    // Reset held with inc asserted: nothing moves.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");

    rst_n = 1'b1;
    inc   = 1'b0;

    // Single word: empty clears after one edge, then the read drains it.
    step(1'b0, 1, "one_wr");
    step(1'b1, 0, "one_rd");
    chk("one_rd:rptr01", 32'(rptr), 32'h01);

    // Read while empty: ignored (and recorded as underflow when enabled).
    step(1'b1, 0, "rd_empty0");
    step(1'b0, 0, "rd_empty1");

    // Fill to level 10 in one visible jump, then read one per cycle.
    step(1'b0, 10, "ae_fill");
    for (int i = 0; i < 11; i++) step(1'b1, 0, "ae_drain");

    // Simultaneous write visibility and read on the same edge.
    step(1'b0, 3, "sim_fill");
    step(1'b1, 1, "sim_rdwr");

    // Random traffic; enough volume to wrap the pointers several times.
    for (int i = 0; i < 800; i++) begin
      int wi;
      wi = ((wr_count - rd_count) < DEPTH) ? int'($urandom_range(0, 1)) : 0;
      step(1'($urandom_range(0, 1)), wi, "rand");
    end

    // Full FIFO boundary: level reaches 2**ADDR_WIDTH.
    while ((wr_count - rd_count) < DEPTH) step(1'b0, 1, "full_fill");
    chk("full:level", 32'(rlevel), 32'(DEPTH));

    // Drain fully, then build level 5 for the asynchronous reset test.
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 0, "drain");
    for (int i = 0; i < 5; i++) step(1'b0, 1, "lvl5");

    // Asynchronous reset between edges: outputs must drop without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    wr_count = 0;
    model_reset();
    check_all("async_rst");
    rq2_wptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 2, "post_rst_wr");
    step(1'b1, 0, "post_rst_rd");
    step(1'b1, 0, "post_rst_rd2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
